cpu_alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the CPU's combinational ALU. Registers operands and result,

---
 rtl/cpu_alu_pkg.sv | 33 +++
 rtl/cpu_alu_bcd_digit.sv | 48 ++++
 rtl/cpu_alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_alu_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_alu_pkg
// Shared types for the sequential CPU ALU:
//   alu_op_e    - 4-bit opcode encoding driven by the decode/sequencer
//   alu_state_e - ALU control FSM states (IDLE, ADJ, HOLD)
//   BCD_DIGIT_W - width of one BCD digit
// -----------------------------------------------------------------------------
package cpu_alu_pkg;

  // Opcodes 10..15 are reserved and produce result 0.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_XOR = 4'd3,
    OP_OR  = 4'd4,
    OP_LSR = 4'd5,
    OP_ASL = 4'd6,
    OP_CMP = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9
  } alu_op_e;

  // ADJ is only reachable when the decimal feature is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADJ  = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

  localparam int BCD_DIGIT_W = 4;

endpackage

// File: rtl/cpu_alu_bcd_digit.sv
// -----------------------------------------------------------------------------
// cpu_alu_bcd_digit
// Combinational single-digit BCD adder/subtractor.
// Ports:
//   a, b   in  4  operand digits
//   cin    in  1  carry in (add) or borrow in (sub)
//   sub    in  1  0 = add, 1 = subtract
//   digit  out 4  adjusted result digit
//   cout   out 1  carry out (add) or borrow out (sub)
// Non-BCD input digits are run through the same formulas; no error is flagged.
// -----------------------------------------------------------------------------
module cpu_alu_bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] d;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // d is a signed 5-bit difference; bit 4 set means it went negative.
    d     = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
    digit = 4'h0;
    cout  = 1'b0;
    if (sub) begin
      if (d[4]) begin
        digit = d[3:0] - 4'd6;
        cout  = 1'b1;
      end else begin
        digit = d[3:0];
      end
    end else begin
      if (s > 5'd9) begin
        // Only the low nibble of s+6 is kept; the carry is reported separately.
        digit = s[3:0] + 4'd6;
        cout  = 1'b1;
      end else begin
        digit = s[3:0];
      end
    end
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// cpu_alu_seq
// Handshaked, registered CPU ALU with N/Z/C/V flags. Sits between the
// decode/sequencer and the register file.
//
// Build option: define CPU_ALU_DECIMAL_EN to honour the decimal input for
// ADD/SUB (digit-serial BCD, one digit per cycle in ADJ). Without it the
// decimal input is ignored and every op completes in one cycle.
//
// Handshake: a request is taken on a rising edge where in_valid & in_ready.
// A result is presented while out_valid=1 and is consumed on a rising edge
// where out_valid & out_ready; until then result/flags do not change and
// in_ready stays low. A new request may be taken on the same edge the
// previous result is consumed (no bubble).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        request handshake
//   op                         alu_op_e opcode
//   in_a, in_b                 operands (WIDTH bits)
//   carry_in                   C flag in (borrow = !carry_in for SUB)
//   decimal                    BCD request for ADD/SUB
//   out_valid / out_ready      result handshake
//   result                     result (WIDTH bits)
//   flag_n/z/c/v               flags of result
//   state_dbg                  current FSM state (alu_state_e encoding)
// -----------------------------------------------------------------------------
module cpu_alu_seq
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carry_in,
  input  logic             decimal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [1:0]       state_dbg
);

  alu_state_e state;
  logic       accept;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Single-cycle binary datapath, evaluated on the request inputs.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] bin_res;
  logic             bin_c;
  logic             bin_v;

  always_comb begin
    sum     = '0;
    bin_res = '0;
    bin_c   = carry_in;
    bin_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
        bin_res = sum[WIDTH-1:0];
        bin_c   = sum[WIDTH];
        bin_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (bin_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        // a - b - !cin computed as a + ~b + cin so C is the inverted borrow.
        sum     = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, carry_in};
        bin_res = sum[WIDTH-1:0];
        bin_c   = sum[WIDTH];
        bin_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (bin_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: bin_res = in_a & in_b;
      OP_XOR: bin_res = in_a ^ in_b;
      OP_OR:  bin_res = in_a | in_b;
      OP_LSR: begin
        bin_res = {carry_in, in_a[WIDTH-1:1]};
        bin_c   = in_a[0];
      end
      OP_ASL: begin
        bin_res = {in_a[WIDTH-2:0], carry_in};
        bin_c   = in_a[WIDTH-1];
      end
      OP_CMP: begin
        // Carry in forced to 1: C is set exactly when a >= b (unsigned).
        sum     = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
        bin_res = sum[WIDTH-1:0];
        bin_c   = sum[WIDTH];
      end
      OP_INC: bin_res = in_a + WIDTH'(1);
      OP_DEC: bin_res = in_a - WIDTH'(1);
      default: bin_res = '0;
    endcase
  end

`ifdef CPU_ALU_DECIMAL_EN
  // ---------------------------------------------------------------------------
  // Digit-serial BCD path: one shared digit unit walks the operands LSD first.
  // ---------------------------------------------------------------------------
  localparam int NDIG = WIDTH / BCD_DIGIT_W;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_fin;
  logic [KW-1:0]    k;
  logic [KW+1:0]    dbase;
  logic             dc;    // running carry (ADD) or borrow (SUB)
  logic             dsub;
  logic             dv;    // V comes from the binary computation
  logic [3:0]       dig;
  logic             dig_cout;
  logic             is_dec;

  assign is_dec = decimal && ((op == OP_ADD) || (op == OP_SUB));
  assign dbase  = {k, 2'b00};

  cpu_alu_bcd_digit u_bcd_digit (
    .a     (a_q[dbase +: 4]),
    .b     (b_q[dbase +: 4]),
    .cin   (dc),
    .sub   (dsub),
    .digit (dig),
    .cout  (dig_cout)
  );

  // Partial result with the current digit merged in.
  always_comb begin
    acc_fin              = acc;
    acc_fin[dbase +: 4]  = dig;
  end
`else
  logic unused_decimal;
  assign unused_decimal = decimal;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
`ifdef CPU_ALU_DECIMAL_EN
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      k      <= '0;
      dc     <= 1'b0;
      dsub   <= 1'b0;
      dv     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
`ifdef CPU_ALU_DECIMAL_EN
            if (is_dec) begin
              state <= ADJ;
              a_q   <= in_a;
              b_q   <= in_b;
              acc   <= '0;
              k     <= '0;
              dsub  <= (op == OP_SUB);
              dc    <= (op == OP_SUB) ? ~carry_in : carry_in;
              dv    <= bin_v;
            end else
`endif
            begin
              state  <= HOLD;
              result <= bin_res;
              flag_n <= bin_res[WIDTH-1];
              flag_z <= (bin_res == '0);
              flag_c <= bin_c;
              flag_v <= bin_v;
            end
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
`ifdef CPU_ALU_DECIMAL_EN
        ADJ: begin
          acc <= acc_fin;
          dc  <= dig_cout;
          k   <= k + KW'(1);
          if (k == K_LAST) begin
            state  <= HOLD;
            result <= acc_fin;
            flag_n <= acc_fin[WIDTH-1];
            flag_z <= (acc_fin == '0);
            flag_c <= dsub ? ~dig_cout : dig_cout;
            flag_v <= dv;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_alu_seq
// Directed bench for cpu_alu_seq (WIDTH=8). Expected results are pushed into
// a queue when a request is accepted; a monitor pops and compares whenever a
// result is consumed. Expectations follow CPU_ALU_DECIMAL_EN when it is set.
// -----------------------------------------------------------------------------
module tb_cpu_alu_seq;
  import cpu_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         carry_in;
  logic         decimal;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;
  logic [1:0]   state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  // {result, n, z, c, v}
  logic [W+3:0] exp_q[$];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  cpu_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .carry_in  (carry_in),
    .decimal   (decimal),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .state_dbg (state_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W+3:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: got %0h want none", result);
        end else begin
          exp = exp_q.pop_front();
          check("result_nzcv", {20'h0, result, flag_n, flag_z, flag_c, flag_v}, {20'h0, exp});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic dec,
                      input logic [W-1:0] er, input logic [3:0] ef);
    logic accepted;
    accepted = 1'b0;
    op       = o;
    in_a     = a;
    in_b     = b;
    carry_in = ci;
    decimal  = dec;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      exp_q.push_back({er, ef});
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: got no in_ready want in_ready within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    decimal  = 1'b0;
  endtask

  // Counts falling edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ci, input logic dec,
                     input logic [W-1:0] er, input logic [3:0] ef, input int lat);
    send(o, a, b, ci, dec, er, ef);
    wait_out(lat);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stale;
    in_valid  = 1'b0;
    op        = 4'h0;
    in_a      = '0;
    in_b      = '0;
    carry_in  = 1'b0;
    decimal   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    check("reset_state", state_dbg, IDLE);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", in_ready, 1);

    // Arithmetic
    run(OP_ADD, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1001, 1);
    run(OP_SUB, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 1);
    run(OP_CMP, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 4'b0110, 1);
    run(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b1001, 1);
    run(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0110, 1);
    run(OP_SUB, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 4'b1001, 1);

    // Decimal ADD/SUB
`ifdef CPU_ALU_DECIMAL_EN
    run(OP_ADD, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 4'b0011, 3);
    run(OP_SUB, 8'h12, 8'h21, 1'b1, 1'b1, 8'h91, 4'b1000, 3);
`else
    run(OP_ADD, 8'h58, 8'h46, 1'b1, 1'b1, 8'h9F, 4'b1001, 1);
    run(OP_SUB, 8'h12, 8'h21, 1'b1, 1'b1, 8'hF1, 4'b1000, 1);
`endif
    // Decimal request on a logic op stays binary
    run(OP_AND, 8'h0F, 8'h35, 1'b0, 1'b1, 8'h05, 4'b0000, 1);

    // Logic, shifts, inc/dec, reserved
    run(OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 4'b0010, 1);
    run(OP_XOR, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 4'b0100, 1);
    run(OP_OR,  8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 4'b1000, 1);
    run(OP_ASL, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 4'b0010, 1);
    run(OP_INC, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0100, 1);
    run(OP_DEC, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b1010, 1);
    run(4'hC,   8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 4'b0110, 1);

    // Back-pressure: result held while out_ready=0, then back-to-back accept
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_result_nzcv", {result, flag_n, flag_z, flag_c, flag_v}, {8'h03, 4'b0000});
      check("hold_in_ready", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    send(OP_LSR, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1010);
    wait_out(1);
    step();

    // Reset in the middle of an operation (ADJ when decimal is built in)
    send(OP_ADD, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 4'b0011);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset_out_valid", out_valid, 0);
    check("midop_reset_result", result, 0);
    check("midop_reset_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("midop_in_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_result", stale, 0);
    step();
    run(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0100, 1);

    // Drain
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    n_vec++;
    n_miss++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
